// File: rtl/bsg_vanilla_remote_req_responder.sv
// Target-side responder: serves remote load/store/AMO on a 1-cycle DMEM port.
// Define BSG_VANILLA_REMOTE_AMO_EN to build the AMO swap/or/add datapath.
module bsg_vanilla_remote_req_responder #(
    parameter int mem_addr_width_p = 10,
    parameter int reg_id_width_p   = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic                        req_v_i,
    output logic                        req_ready_o,
    input  logic                        req_write_not_read_i,
    input  logic                        req_is_amo_i,
    input  logic [1:0]                  req_amo_type_i,
    input  logic [3:0]                  req_mask_i,
    input  logic [reg_id_width_p-1:0]   req_reg_id_i,
    input  logic [31:0]                 req_data_i,
    input  logic [31:0]                 req_addr_i,

    output logic                        mem_v_o,
    output logic                        mem_w_o,
    output logic [mem_addr_width_p-1:0] mem_addr_o,
    output logic [31:0]                 mem_data_o,
    output logic [3:0]                  mem_mask_o,
    input  logic [31:0]                 mem_data_i,

    output logic                        resp_v_o,
    input  logic                        resp_ready_i,
    output logic [reg_id_width_p-1:0]   resp_reg_id_o,
    output logic [31:0]                 resp_data_o,
    output logic                        resp_is_write_o,
    output logic                        resp_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_e;

    state_e state_r, state_n;

    logic                        accept;
    logic                        addr_err;
    logic                        op_err;

    logic                        w_r;
    logic                        err_r;
    logic [3:0]                  mask_r;
    logic [reg_id_width_p-1:0]   reg_id_r;
    logic [31:0]                 data_r;
    logic [mem_addr_width_p-1:0] addr_r;

    logic [31:0]                 resp_data_r;
    logic                        resp_is_write_r;
    logic                        resp_err_r;

    logic                        unused_ok;

`ifdef BSG_VANILLA_REMOTE_AMO_EN
    logic                        amo_r;
    logic [1:0]                  amo_type_r;
    logic [31:0]                 amo_new;
`endif

    assign req_ready_o = (state_r == IDLE) & reset_n_i;
    assign accept      = req_v_i & req_ready_o;
    assign addr_err    = |req_addr_i[31:2+mem_addr_width_p];

`ifdef BSG_VANILLA_REMOTE_AMO_EN
    assign op_err    = req_is_amo_i & (req_amo_type_i == 2'd3);
    assign unused_ok = ^req_addr_i[1:0];
`else
    assign op_err    = req_is_amo_i;
    assign unused_ok = ^{req_addr_i[1:0], req_amo_type_i};
`endif

    // Errors are resolved at accept so ACCESS only has to branch on one bit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_r      <= 1'b0;
            err_r    <= 1'b0;
            mask_r   <= '0;
            reg_id_r <= '0;
            data_r   <= '0;
            addr_r   <= '0;
        end else if (accept) begin
            w_r      <= req_write_not_read_i & ~req_is_amo_i;
            err_r    <= addr_err | op_err;
            mask_r   <= req_mask_i;
            reg_id_r <= req_reg_id_i;
            data_r   <= req_data_i;
            addr_r   <= req_addr_i[2+:mem_addr_width_p];
        end
    end

`ifdef BSG_VANILLA_REMOTE_AMO_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            amo_r      <= 1'b0;
            amo_type_r <= 2'd0;
        end else if (accept) begin
            amo_r      <= req_is_amo_i;
            amo_type_r <= req_amo_type_i;
        end
    end

    always_comb begin
        amo_new = mem_data_i + data_r;
        unique case (amo_type_r)
            2'd0:    amo_new = data_r;
            2'd1:    amo_new = mem_data_i | data_r;
            default: amo_new = mem_data_i + data_r;
        endcase
    end
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_data_r     <= '0;
            resp_is_write_r <= 1'b0;
            resp_err_r      <= 1'b0;
        end else begin
            unique case (state_r)
                ACCESS: begin
                    if (err_r | w_r) begin
                        resp_data_r     <= '0;
                        resp_is_write_r <= ~err_r;
                        resp_err_r      <= err_r;
                    end
                end
                WAIT: begin
                    resp_data_r     <= mem_data_i;
                    resp_is_write_r <= 1'b0;
                    resp_err_r      <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_n    = state_r;
        mem_v_o    = 1'b0;
        mem_w_o    = 1'b0;
        mem_mask_o = 4'h0;
        mem_data_o = '0;
        unique case (state_r)
            IDLE: begin
                if (accept) state_n = ACCESS;
            end
            ACCESS: begin
                if (err_r) begin
                    state_n = RESP;
                end else if (w_r) begin
                    mem_v_o    = 1'b1;
                    mem_w_o    = 1'b1;
                    mem_mask_o = mask_r;
                    mem_data_o = data_r;
                    state_n    = RESP;
                end else begin
                    mem_v_o = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                state_n = RESP;
`ifdef BSG_VANILLA_REMOTE_AMO_EN
                if (amo_r) begin
                    mem_v_o    = 1'b1;
                    mem_w_o    = 1'b1;
                    mem_mask_o = 4'hF;
                    mem_data_o = amo_new;
                end
`endif
            end
            RESP: begin
                if (resp_ready_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_addr_o      = mem_v_o ? addr_r : '0;
    assign resp_v_o        = (state_r == RESP);
    assign resp_reg_id_o   = reg_id_r;
    assign resp_data_o     = resp_data_r;
    assign resp_is_write_o = resp_is_write_r;
    assign resp_err_o      = resp_err_r;

endmodule

// File: tb/tb_bsg_vanilla_remote_req_responder.sv
// Bench for bsg_vanilla_remote_req_responder: directed table, corner sequences,
// randomized traffic against a word-level reference memory.
module tb_bsg_vanilla_remote_req_responder;

`ifdef BSG_VANILLA_REMOTE_AMO_EN
    localparam bit AMO_EN = 1'b1;
`else
    localparam bit AMO_EN = 1'b0;
`endif
    localparam int AW = 10;
    localparam int RW = 5;

    typedef struct {
        logic        w;
        logic        amo;
        logic [1:0]  ty;
        logic [3:0]  mask;
        logic [4:0]  id;
        logic [31:0] data;
        logic [31:0] addr;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        wr;
        logic [4:0]  id;
        int          lat;
        int          nrd;
        int          nwr;
        logic        rdy;
    } res_t;

    typedef struct {
        txn_t        t;
        logic [31:0] e_data;
        logic        e_err;
        logic        e_wr;
        int          e_lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_v = 1'b0;
    logic          req_ready;
    logic          req_w = 1'b0;
    logic          req_amo = 1'b0;
    logic [1:0]    req_ty = 2'd0;
    logic [3:0]    req_mask = 4'h0;
    logic [RW-1:0] req_id = '0;
    logic [31:0]   req_data = '0;
    logic [31:0]   req_addr = '0;
    logic          mem_v;
    logic          mem_w;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_mask;
    logic [31:0]   mem_rdata = '0;
    logic          resp_v;
    logic          resp_ready = 1'b0;
    logic [RW-1:0] resp_id;
    logic [31:0]   resp_data;
    logic          resp_wr;
    logic          resp_err;

    logic [31:0] sram    [1024] = '{default: '0};
    logic [31:0] ref_mem [1024] = '{default: '0};
    int n_rd = 0;
    int n_wr = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bsg_vanilla_remote_req_responder #(
        .mem_addr_width_p(AW),
        .reg_id_width_p  (RW)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .req_v_i             (req_v),
        .req_ready_o         (req_ready),
        .req_write_not_read_i(req_w),
        .req_is_amo_i        (req_amo),
        .req_amo_type_i      (req_ty),
        .req_mask_i          (req_mask),
        .req_reg_id_i        (req_id),
        .req_data_i          (req_data),
        .req_addr_i          (req_addr),
        .mem_v_o             (mem_v),
        .mem_w_o             (mem_w),
        .mem_addr_o          (mem_addr),
        .mem_data_o          (mem_wdata),
        .mem_mask_o          (mem_mask),
        .mem_data_i          (mem_rdata),
        .resp_v_o            (resp_v),
        .resp_ready_i        (resp_ready),
        .resp_reg_id_o       (resp_id),
        .resp_data_o         (resp_data),
        .resp_is_write_o     (resp_wr),
        .resp_err_o          (resp_err)
    );

    // DMEM: one-cycle read latency, byte-masked writes
    always @(posedge clk) begin
        if (mem_v) begin
            if (mem_w) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) sram[mem_addr][8*b+:8] <= mem_wdata[8*b+:8];
                n_wr = n_wr + 1;
            end else begin
                mem_rdata <= sram[mem_addr];
                n_rd = n_rd + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Word-level reference: what each request should return and do to memory.
    task automatic ref_txn(input txn_t t, output res_t e);
        int unsigned wd;
        logic [31:0] old;
        wd = (t.addr >> 2) & 32'h3FF;
        old = ref_mem[wd];
        e.id = t.id;
        e.rdy = 1'b1;
        if ((t.addr >> (2 + AW)) != 0 || (t.amo && (!AMO_EN || t.ty == 2'd3))) begin
            e.data = 0; e.err = 1; e.wr = 0; e.lat = 2; e.nrd = 0; e.nwr = 0;
        end else if (t.amo) begin
            case (t.ty)
                2'd0: ref_mem[wd] = t.data;
                2'd1: ref_mem[wd] = old | t.data;
                default: ref_mem[wd] = old + t.data;
            endcase
            e.data = old; e.err = 0; e.wr = 0; e.lat = 3; e.nrd = 1; e.nwr = 1;
        end else if (t.w) begin
            for (int b = 0; b < 4; b++)
                if (t.mask[b]) ref_mem[wd][8*b+:8] = t.data[8*b+:8];
            e.data = 0; e.err = 0; e.wr = 1; e.lat = 2; e.nrd = 0; e.nwr = 1;
        end else begin
            e.data = old; e.err = 0; e.wr = 0; e.lat = 3; e.nrd = 1; e.nwr = 0;
        end
    endtask

    task automatic drive(input txn_t t);
        req_w = t.w; req_amo = t.amo; req_ty = t.ty; req_mask = t.mask;
        req_id = t.id; req_data = t.data; req_addr = t.addr;
    endtask

    task automatic run_txn(input txn_t t, input int stall, output res_t r);
        int rd0, wr0;
        @(negedge clk);
        rd0 = n_rd; wr0 = n_wr;
        drive(t);
        req_v = 1'b1;
        r.rdy = req_ready;
        @(posedge clk);
        #1 req_v = 1'b0;
        r.lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (resp_v) begin
                r.lat = i;
                break;
            end
        end
        r.data = resp_data; r.err = resp_err; r.wr = resp_wr; r.id = resp_id;
        repeat (stall) @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        r.nrd = n_rd - rd0;
        r.nwr = n_wr - wr0;
    endtask

    task automatic cmp(input string tag, input res_t r, input res_t e);
        chk({tag, " ready"}, 32'(r.rdy), 32'(e.rdy));
        chk({tag, " lat"}, r.lat, e.lat);
        chk({tag, " data"}, r.data, e.data);
        chk({tag, " err"}, 32'(r.err), 32'(e.err));
        chk({tag, " is_write"}, 32'(r.wr), 32'(e.wr));
        chk({tag, " reg_id"}, 32'(r.id), 32'(e.id));
        chk({tag, " mem_reads"}, r.nrd, e.nrd);
        chk({tag, " mem_writes"}, r.nwr, e.nwr);
    endtask

    function automatic txn_t mk(logic w, logic amo, logic [1:0] ty, logic [3:0] mask,
                                logic [4:0] id, logic [31:0] data, logic [31:0] addr);
        txn_t t;
        t.w = w; t.amo = amo; t.ty = ty; t.mask = mask;
        t.id = id; t.data = data; t.addr = addr;
        return t;
    endfunction

    initial begin
        vec_t  vecs [17];
        txn_t  t;
        res_t  r, e;
        logic [31:0] held_data;
        logic [4:0]  held_id;
        int    wr0, bad;

        vecs[0]  = '{mk(1, 0, 0, 4'hF, 1, 32'hDEADBEEF, 32'h10), 32'h0, 0, 1, 2};
        vecs[1]  = '{mk(0, 0, 0, 4'h0, 5, 32'h0, 32'h10), 32'hDEADBEEF, 0, 0, 3};
        vecs[2]  = '{mk(1, 0, 0, 4'b0010, 2, 32'h0000AA00, 32'h10), 32'h0, 0, 1, 2};
        vecs[3]  = '{mk(0, 0, 0, 4'hF, 3, 32'h0, 32'h10), 32'hDEADAAEF, 0, 0, 3};
        vecs[4]  = '{mk(0, 0, 0, 4'hF, 4, 32'h0, 32'h1 << (2 + AW)), 32'h0, 1, 0, 2};
        vecs[5]  = '{mk(1, 0, 0, 4'hF, 6, 32'hFFFFFFFF, 32'h20), 32'h0, 0, 1, 2};
        vecs[6]  = '{mk(0, 1, 2, 4'h0, 7, 32'h1, 32'h20),
                     AMO_EN ? 32'hFFFFFFFF : 32'h0, !AMO_EN, 0, AMO_EN ? 3 : 2};
        vecs[7]  = '{mk(0, 0, 0, 4'h0, 8, 32'h0, 32'h20),
                     AMO_EN ? 32'h0 : 32'hFFFFFFFF, 0, 0, 3};
        vecs[8]  = '{mk(1, 0, 0, 4'hF, 9, 32'h100, 32'h30), 32'h0, 0, 1, 2};
        vecs[9]  = '{mk(0, 1, 1, 4'h0, 10, 32'hF0, 32'h30),
                     AMO_EN ? 32'h100 : 32'h0, !AMO_EN, 0, AMO_EN ? 3 : 2};
        vecs[10] = '{mk(0, 0, 0, 4'h0, 11, 32'h0, 32'h30),
                     AMO_EN ? 32'h1F0 : 32'h100, 0, 0, 3};
        vecs[11] = '{mk(0, 1, 3, 4'h0, 12, 32'h5, 32'h30), 32'h0, 1, 0, 2};
        vecs[12] = '{mk(1, 0, 0, 4'h0, 13, 32'hFFFFFFFF, 32'h10), 32'h0, 0, 1, 2};
        vecs[13] = '{mk(0, 0, 0, 4'h0, 14, 32'h0, 32'h13), 32'hDEADAAEF, 0, 0, 3};
        vecs[14] = '{mk(1, 1, 0, 4'h0, 15, 32'hCAFEF00D, 32'h30),
                     AMO_EN ? 32'h1F0 : 32'h0, !AMO_EN, 0, AMO_EN ? 3 : 2};
        vecs[15] = '{mk(0, 0, 0, 4'h0, 16, 32'h0, 32'h30),
                     AMO_EN ? 32'hCAFEF00D : 32'h100, 0, 0, 3};
        vecs[16] = '{mk(1, 0, 0, 4'hF, 17, 32'h1234, 32'hFFFF0010), 32'h0, 1, 0, 2};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 0);
        chk("rst resp_v", 32'(resp_v), 0);
        chk("rst mem_v", 32'(mem_v), 0);
        chk("rst resp_data", resp_data, 0);
        chk("rst resp_err", 32'(resp_err), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post-rst req_ready", 32'(req_ready), 1);

        // directed table
        foreach (vecs[i]) begin
            run_txn(vecs[i].t, 0, r);
            ref_txn(vecs[i].t, e);
            e.data = vecs[i].e_data;
            e.err  = vecs[i].e_err;
            e.wr   = vecs[i].e_wr;
            e.lat  = vecs[i].e_lat;
            cmp($sformatf("vec%0d", i), r, e);
        end

        // backpressure: response held 10 cycles, no new accept
        @(negedge clk);
        t = mk(0, 0, 0, 4'h0, 5'd7, 32'h0, 32'h10);
        ref_txn(t, e);
        drive(t);
        req_v = 1'b1;
        @(posedge clk);
        #1 req_v = 1'b0;
        bad = 1;
        for (int i = 0; i < 20 && bad == 1; i++) begin
            @(negedge clk);
            if (resp_v) bad = 0;
        end
        chk("bp resp arrives", 32'(bad), 0);
        held_data = resp_data;
        held_id = resp_id;
        chk("bp data", held_data, e.data);
        chk("bp reg_id", 32'(held_id), 7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d", i),
                {resp_v, req_ready, resp_id, resp_data[24:0]},
                {1'b1, 1'b0, held_id, held_data[24:0]});
            chk($sformatf("bp hold%0d hi", i), resp_data, held_data);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("bp released ready", 32'(req_ready), 1);

        // reset during WAIT: AMO write (or load) abandoned, no response
        @(negedge clk);
        t = mk(0, AMO_EN, 2'd2, 4'h0, 5'd9, 32'h11, 32'h40);
        drive(t);
        req_v = 1'b1;
        @(posedge clk);
        #1 req_v = 1'b0;
        wr0 = n_wr;
        @(posedge clk);
        #1 reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid-rst resp_v", 32'(resp_v), 0);
            chk("mid-rst req_ready", 32'(req_ready), 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid-rst writes", n_wr - wr0, 0);
        chk("mid-rst mem word", sram[16], ref_mem[16]);
        chk("mid-rst ready after", 32'(req_ready), 1);
        chk("mid-rst no resp", 32'(resp_v), 0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            int k;
            k = $urandom % 8;
            t = mk($urandom % 2, 0, $urandom % 4, $urandom % 16, $urandom % 32,
                   $urandom, (($urandom % 16) << 2) | ($urandom % 4));
            if (k < 3) t.w = 1'b1;
            else if (k < 6) t.w = 1'b0;
            else if (k == 6) t.amo = 1'b1;
            else begin
                t.addr = $urandom;
                if ((t.addr >> (2 + AW)) == 0) t.addr[2+AW] = 1'b1;
            end
            ref_txn(t, e);
            run_txn(t, $urandom % 3, r);
            cmp($sformatf("rnd%0d", n), r, e);
        end

        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (sram[i] !== ref_mem[i]) begin
                if (bad < 4) $display("  word %0d: dmem %h model %h", i, sram[i], ref_mem[i]);
                bad++;
            end
        end
        chk("final memory image mismatches", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
